// File: rtl/ip_debug_bus_pkg.sv
// +--------------------------------------------------------------------------+
// | ip_debug_bus_pkg : state encoding and VDP port numbers shared with the   |
// |                    debugger command sequencer                            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package ip_debug_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_ACK     = 2'd3
  } bridge_state_e;

  localparam logic [1:0] VDP_PORT0 = 2'd0;
  localparam logic [1:0] VDP_PORT1 = 2'd1;
  localparam logic [1:0] VDP_PORT2 = 2'd2;
  localparam logic [1:0] VDP_PORT3 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ip_debug_bus_bridge.sv
// +--------------------------------------------------------------------------+
// | ip_debug_bus_bridge : 4-phase req/ack to VDP valid/ready bridge with a   |
// |                       recovery gap; optional abort timer enabled by      |
// |                       IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN                     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module ip_debug_bus_bridge
  import ip_debug_bus_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       ack,
  input  logic       wr,
  input  logic [1:0] address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       vdp_valid,
  input  logic       vdp_ready,
  output logic       vdp_write,
  output logic [1:0] vdp_address,
  output logic [7:0] vdp_wdata,
  input  logic [7:0] vdp_rdata,
  input  logic       vdp_rdata_en,
  output logic       timeout_err
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  bridge_state_e    state_q;
  logic [GAP_W-1:0] gap_q;
  logic             ack_q;
  logic [7:0]       rdata_q;
  logic             vdp_valid_q;
  logic             vdp_write_q;
  logic [1:0]       vdp_address_q;
  logic [7:0]       vdp_wdata_q;

`ifdef IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_q;
  logic            timeout_err_q;
  logic            timeout_hit;

  // wait_q counts cycles already spent, so this is the TIMEOUT_CYCLES-th one
  assign timeout_hit = (wait_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gap_q         <= '0;
      ack_q         <= 1'b0;
      rdata_q       <= 8'h00;
      vdp_valid_q   <= 1'b0;
      vdp_write_q   <= 1'b0;
      vdp_address_q <= VDP_PORT0;
      vdp_wdata_q   <= 8'h00;
`ifdef IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
          end else if (req) begin
            vdp_valid_q   <= 1'b1;
            vdp_write_q   <= wr;
            vdp_address_q <= address;
            vdp_wdata_q   <= wdata;
            state_q       <= ST_ISSUE;
`ifdef IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN
            wait_q        <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (vdp_ready) begin
            vdp_valid_q <= 1'b0;
            if (vdp_write_q) begin
              ack_q   <= 1'b1;
              state_q <= ST_ACK;
            end else if (vdp_rdata_en) begin
              rdata_q <= vdp_rdata;
              ack_q   <= 1'b1;
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT_RD;
`ifdef IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN
              wait_q  <= '0;
`endif
            end
`ifdef IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN
          end else if (timeout_hit) begin
            vdp_valid_q   <= 1'b0;
            if (!vdp_write_q) rdata_q <= 8'hFF;
            timeout_err_q <= 1'b1;
            ack_q         <= 1'b1;
            state_q       <= ST_ACK;
          end else begin
            wait_q <= wait_q + TO_W'(1);
`endif
          end
        end
        ST_WAIT_RD: begin
          if (vdp_rdata_en) begin
            rdata_q <= vdp_rdata;
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
`ifdef IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN
          end else if (timeout_hit) begin
            rdata_q       <= 8'hFF;
            timeout_err_q <= 1'b1;
            ack_q         <= 1'b1;
            state_q       <= ST_ACK;
          end else begin
            wait_q <= wait_q + TO_W'(1);
`endif
          end
        end
        ST_ACK: begin
          if (!req) begin
            ack_q   <= 1'b0;
            gap_q   <= GAP_LOAD;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign vdp_valid   = vdp_valid_q;
  assign vdp_write   = vdp_write_q;
  assign vdp_address = vdp_address_q;
  assign vdp_wdata   = vdp_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ip_debug_bus_bridge.sv
// +--------------------------------------------------------------------------+
// | tb_ip_debug_bus_bridge : directed bench with VDP access scoreboard       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ip_debug_bus_bridge;
  import ip_debug_bus_pkg::*;

  localparam int GAP = 16;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] address = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic       ack;
  logic [7:0] rdata;
  logic       vdp_valid;
  logic       vdp_ready = 1'b0;
  logic       vdp_write;
  logic [1:0] vdp_address;
  logic [7:0] vdp_wdata;
  logic [7:0] vdp_rdata = 8'h00;
  logic       vdp_rdata_en = 1'b0;
  logic       timeout_err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          push_cnt = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;
  logic [7:0]  exp_rdata = 8'h00;

  ip_debug_bus_bridge #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .wr(wr), .address(address),
    .wdata(wdata), .rdata(rdata), .vdp_valid(vdp_valid), .vdp_ready(vdp_ready),
    .vdp_write(vdp_write), .vdp_address(vdp_address), .vdp_wdata(vdp_wdata),
    .vdp_rdata(vdp_rdata), .vdp_rdata_en(vdp_rdata_en), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic w, input logic [1:0] a, input logic [7:0] d);
    req = 1'b1; wr = w; address = a; wdata = d;
    exp_q.push_back({w, a, d});
    push_cnt++;
  endtask

  task automatic wait_valid(input int bound, output int cycles);
    cycles = 0;
    while (vdp_valid !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
    check("valid_seen", vdp_valid, 1);
  endtask

  // VDP side: ready after rdy_dly cycles; read strobe rd_dly cycles after ready
  task automatic serve(input int rdy_dly, input int rd_dly, input logic [7:0] rdv);
    logic is_rd;
    is_rd = ~vdp_write;
    repeat (rdy_dly) tick();
    vdp_ready = 1'b1;
    if (is_rd && rd_dly == 0) begin vdp_rdata_en = 1'b1; vdp_rdata = rdv; end
    tick();
    vdp_ready = 1'b0; vdp_rdata_en = 1'b0;
    if (is_rd && rd_dly > 0) begin
      repeat (rd_dly - 1) tick();
      vdp_rdata_en = 1'b1; vdp_rdata = rdv;
      tick();
      vdp_rdata_en = 1'b0;
    end
    check("ack_rise", ack, 1);
    check("valid_drop", vdp_valid, 0);
    if (is_rd) exp_rdata = rdv;
    check("rdata", rdata, exp_rdata);
  endtask

  task automatic finish_req();
    req = 1'b0;
    tick();
    check("ack_fall", ack, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_valid", vdp_valid, 0);
    check("rst_write", vdp_write, 0);
    check("rst_addr", vdp_address, 0);
    check("rst_wdata", vdp_wdata, 8'h00);
    check("rst_terr", timeout_err, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && vdp_valid === 1'b1 && vdp_ready === 1'b1) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL sb_unexpected: observed %0h, expected no access", {vdp_write, vdp_address, vdp_wdata});
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_access", {vdp_write, vdp_address, vdp_wdata}, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int base;
    repeat (3) tick();
    check_reset_outputs();
    reset = 1'b0;
    tick();

    // Zero-wait write: valid for exactly one cycle, ack one cycle later
    vdp_ready = 1'b1;
    start(1'b1, VDP_PORT1, 8'h50);
    tick();
    check("zw_valid", vdp_valid, 1);
    check("zw_addr", vdp_address, 1);
    check("zw_wdata", vdp_wdata, 8'h50);
    check("zw_write", vdp_write, 1);
    check("zw_ack_low", ack, 0);
    tick();
    check("zw_valid_low", vdp_valid, 0);
    check("zw_ack", ack, 1);
    vdp_ready = 1'b0;
    finish_req();

    // Read with delayed ready and delayed data, then a write leaving rdata alone
    start(1'b0, VDP_PORT2, 8'h00);
    wait_valid(40, c);
    check("rd_addr", vdp_address, 2);
    serve(3, 2, 8'hA5);
    finish_req();
    start(1'b1, VDP_PORT3, 8'h3C);
    wait_valid(40, c);
    serve(0, 0, 8'h00);
    finish_req();

    // Gap: req raised right after ack fell
    start(1'b1, VDP_PORT0, 8'h77);
    wait_valid(40, c);
    check("gap_cycles", c, GAP + 1);
    serve(1, 0, 8'h00);
    finish_req();

    // Back-to-back register writes
    base = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      start(1'b1, 2'(i), 8'(17 * i));
      wait_valid(40, c);
      serve(i % 3, 0, 8'h00);
      finish_req();
    end
    check("b2b_count", acc_cnt - base, 8);

    // Reset while waiting for read data; req held high across reset release
    start(1'b0, VDP_PORT1, 8'h00);
    wait_valid(40, c);
    vdp_ready = 1'b1;
    tick();
    vdp_ready = 1'b0;
    tick();
    reset = 1'b1;
    start(1'b1, VDP_PORT3, 8'hC3);
    tick();
    check_reset_outputs();
    exp_rdata = 8'h00;
    reset = 1'b0;
    tick();
    check("post_rst_accept", vdp_valid, 1);
    check("post_rst_wdata", vdp_wdata, 8'hC3);
    serve(0, 0, 8'h00);
    finish_req();

`ifdef IP_DEBUG_BUS_BRIDGE_TIMEOUT_EN
    // Read with no VDP response aborts
    req = 1'b1; wr = 1'b0; address = VDP_PORT2;
    wait_valid(40, c);
    c = 0;
    while (ack !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    check("to_ack", ack, 1);
    check("to_valid", vdp_valid, 0);
    check("to_rdata", rdata, 8'hFF);
    check("to_err", timeout_err, 1);
    finish_req();
    repeat (3) tick();
    check("to_err_sticky", timeout_err, 1);
    reset = 1'b1;
    tick();
    check("to_err_reset", timeout_err, 0);
    reset = 1'b0;
    tick();
`else
    check("terr_tied", timeout_err, 0);
`endif

    check("sb_drained", exp_q.size(), 0);
    check("access_count", acc_cnt, push_cnt);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
